rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Round-robin arbiter that shares one 4-way resource (bus, memory port or register-file write port) between four requesters.
- Produces a registered 2-bit grant index plus matching active-low one-hot grant lines, identical to the 2-to-4 active-low select encoding used in the datapath.
- Enforces a maximum tenure per grant so no requester can hold the resource indefinitely.
- Sits between the requesting units and the shared resource's select decode.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles a single grant may be held; legal range 2..255.
- CNT_W, 8, width of the tenure counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising clk.
- req  input  4  request lines, active-high, level-held by each requester for as long as it wants the resource.
- grant_idx  output  2  index of the current owner; meaningful only when busy=1.
- grant_n  output  4  active-low one-hot grant; grant_n[i]=0 iff busy=1 and grant_idx=i; 4'b1111 when idle.
- busy  output  1  resource currently granted.
- timeout  output  1  one-cycle pulse in the cycle after a grant is revoked by tenure expiry.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - grant_idx=2'b00, grant_n=4'b1111, busy=0, timeout=0.
  - Tenure counter cleared; state=IDLE.
  - last_winner=2'b11, so requester 0 has top priority on the first arbitration.
  - Reset overrides everything mid-grant; the grant drops on the same edge.
- All outputs are registered; no combinational path from req to any output.
- State machine: IDLE, OWNED.
- IDLE:
  - If req==0, stay in IDLE.
  - Else pick the winner by rotating priority: last_winner+1, +2, +3, +4 (mod 4), first set bit wins.
  - Next edge: state=OWNED, busy=1, grant_idx=winner, grant_n[winner]=0, counter=0, last_winner=winner.
  - Latency: req asserted in cycle N gives a grant visible in cycle N+1.
- OWNED, hold: req[owner]=1 and counter<MAX_HOLD-1. Counter increments each cycle; grant is unchanged.
- OWNED, voluntary release: req[owner]=0 at an edge.
  - If any other req is set, hand off directly with no idle bubble; the winner is chosen by rotation starting at owner+1.
  - Else go to IDLE: busy=0, grant_n=4'b1111.
  - timeout stays 0.
- OWNED, tenure expiry: req[owner]=1 and counter==MAX_HOLD-1.
  - If other requests are pending, hand off by rotation from owner+1 and assert timeout=1 for the following cycle only.
  - If no other request is pending, re-grant the same owner with counter=0; timeout stays 0.
- Simultaneous release and expiry in the same cycle: treated as voluntary release; no timeout pulse.
- The owner's own req bit is excluded from handoff arbitration in both release cases.
- A requester that drops req while not granted is simply not considered; no request is latched.
- Max cycles owned per grant = MAX_HOLD; a granted requester always gets at least 1 cycle.
- Fairness guarantee: under continuous contention, each requester is granted within 3*MAX_HOLD cycles of asserting req.
- Counter arithmetic is unsigned CNT_W bits and never wraps, because it is cleared on every grant.
- Invariant: grant_n is always either all-ones or exactly one zero, and it always matches grant_idx.

Test Plan:
- Reset then req=4'b0110 held → 1 cycle later busy=1, grant_idx=1, grant_n=4'b1101. Drop req[1] → next cycle grant_idx=2, grant_n=4'b1011, with no bubble.
- req=4'b1111 held continuously with MAX_HOLD=8:
  - grants rotate 0→1→2→3→0, each lasting exactly 8 cycles;
  - timeout pulses once per handoff (cycles 9, 17, 25 after the first grant).
- Single requester req=4'b1000 held for 20 cycles → grant_idx=3 throughout, grant_n=4'b0111, busy never drops, timeout never asserts.
- Owner 2 drops req at the same edge its counter hits 7 while req[0]=1 → next cycle grant_idx=0, timeout=0.
- Grant active (owner 1, counter=4), rst_n=0 for one cycle → on that edge busy=0, grant_n=4'b1111. After release, req=4'b1010 → grant_idx=1, since reset restores last_winner=3.
- Random req for 10k cycles → checker confirms grant_n is one-hot-low or 4'b1111, matches grant_idx/busy, tenure ≤ MAX_HOLD, and wait ≤ 24 cycles.

Source files
------------

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The arbiter takes the slave side and the requesting units take the master side.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [1:0] grant_idx;
  logic [3:0] grant_n;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    input  grant_idx,
    input  grant_n,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output grant_idx,
    output grant_n,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with bounded tenure and registered active-low grant lines.
// A grant is held until the owner releases it or its tenure of MAX_HOLD cycles expires.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter4_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_n_q, grant_n_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       others_s;
  logic             expire_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Descending scan so the candidate closest to start is assigned last and wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] win;
    win = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req_v[idx]) begin
        win = idx;
      end
    end
    return win;
  endfunction

  assign others_s = bus.req & ~onehot(owner_q);
  assign expire_s = (cnt_q == CNT_W'(MAX_HOLD - 1));

  // Next-state, tenure and grant decode for the IDLE/OWNED machine.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = OWNED;
          owner_d = rr_pick(bus.req, last_q + 2'd1);
          last_d  = owner_d;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWNED: begin
        if (!bus.req[owner_q]) begin
          // Voluntary release wins over a coincident expiry: never a timeout pulse.
          if (|others_s) begin
            owner_d = rr_pick(others_s, owner_q + 2'd1);
            last_d  = owner_d;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (expire_s) begin
          if (|others_s) begin
            owner_d   = rr_pick(others_s, owner_q + 2'd1);
            last_d    = owner_d;
            timeout_d = 1'b1;
          end else begin
            owner_d = owner_q;
          end
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == OWNED) begin
      grant_n_d = ~onehot(owner_d);
    end else begin
      grant_n_d = 4'b1111;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 2'b00;
      last_q    <= 2'b11;
      cnt_q     <= '0;
      grant_n_q <= 4'b1111;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      grant_n_q <= grant_n_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant_idx = owner_q;
  assign bus.grant_n   = grant_n_q;
  assign bus.busy      = (state_q == OWNED);
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios plus random requests, all checked
// against a cycle-level reference model of the arbitration rules.
module tb_rr_arbiter4;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arbiter4_if arb_if ();

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner as an integer, tenure counted as cycles held so far.
  bit m_busy;
  int m_owner;
  int m_held;
  int m_last;
  bit m_timeout;
  int wait_cnt [4];
  int max_wait = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input bit [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge(input bit [3:0] r, input bit rn);
    bit [3:0] others;
    int w;
    m_timeout = 1'b0;
    if (!rn) begin
      m_busy = 1'b0; m_owner = 0; m_held = 0; m_last = 3;
    end else if (!m_busy) begin
      if (r != 4'b0000) begin
        w = rr_pick(r, (m_last + 1) % 4);
        m_busy = 1'b1; m_owner = w; m_held = 1; m_last = w;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        if (others != 4'b0000) begin
          w = rr_pick(others, (m_owner + 1) % 4);
          m_owner = w; m_held = 1; m_last = w;
        end else begin
          m_busy = 1'b0;
        end
      end else if (m_held == MAX_HOLD) begin
        if (others != 4'b0000) begin
          w = rr_pick(others, (m_owner + 1) % 4);
          m_owner = w; m_last = w; m_timeout = 1'b1;
        end
        m_held = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step(input bit [3:0] r, input bit rn);
    logic [3:0] exp_gn;
    logic shape_ok;
    arb_if.req = r;
    rst_n = rn;
    for (int i = 0; i < 4; i++) begin
      if (rn && r[i] && !(arb_if.busy && arb_if.grant_idx == i)) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    @(posedge clk);
    model_edge(r, rn);
    #1;
    exp_gn = 4'b1111;
    if (m_busy) exp_gn[m_owner] = 1'b0;
    check_eq("busy", arb_if.busy, m_busy);
    check_eq("grant_n", arb_if.grant_n, exp_gn);
    check_eq("timeout", arb_if.timeout, m_timeout);
    if (m_busy) check_eq("grant_idx", arb_if.grant_idx, m_owner);
    shape_ok = (!arb_if.busy && arb_if.grant_n == 4'b1111) ||
               (arb_if.busy && arb_if.grant_n == ~(4'b0001 << arb_if.grant_idx));
    check_eq("grant_shape", shape_ok, 1'b1);
  endtask

  initial begin
    bit [3:0] r;
    arb_if.req = 4'b0000;
    rst_n = 1'b0;
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    check_eq("rst_busy", arb_if.busy, 1'b0);
    check_eq("rst_grant_n", arb_if.grant_n, 4'b1111);
    check_eq("rst_idx", arb_if.grant_idx, 2'b00);

    // Rotation from last_winner=3 picks 1 out of 0110, then a bubble-free handoff to 2.
    step(4'b0110, 1'b1);
    check_eq("s1_idx", arb_if.grant_idx, 2'd1);
    check_eq("s1_gn", arb_if.grant_n, 4'b1101);
    step(4'b0100, 1'b1);
    check_eq("s1_hand_idx", arb_if.grant_idx, 2'd2);
    check_eq("s1_hand_gn", arb_if.grant_n, 4'b1011);
    check_eq("s1_hand_busy", arb_if.busy, 1'b1);

    // Full contention: 8-cycle tenures rotating 0..3, timeout at each handoff.
    step(4'b0000, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step(4'b1111, 1'b1);
      check_eq("s2_idx", arb_if.grant_idx, ((k - 1) / MAX_HOLD) % 4);
      check_eq("s2_timeout", arb_if.timeout, (k > 1) && ((k - 1) % MAX_HOLD == 0));
    end

    // Lone requester is re-granted on expiry without a timeout.
    step(4'b0000, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(4'b1000, 1'b1);
      check_eq("s3_idx", arb_if.grant_idx, 2'd3);
      check_eq("s3_gn", arb_if.grant_n, 4'b0111);
      check_eq("s3_busy", arb_if.busy, 1'b1);
      check_eq("s3_timeout", arb_if.timeout, 1'b0);
    end

    // Release coinciding with expiry counts as voluntary.
    step(4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) step(4'b0100, 1'b1);
    step(4'b0001, 1'b1);
    check_eq("s4_idx", arb_if.grant_idx, 2'd0);
    check_eq("s4_timeout", arb_if.timeout, 1'b0);

    // Reset mid-grant drops the grant and restores last_winner=3.
    step(4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0010, 1'b1);
    step(4'b0010, 1'b0);
    check_eq("s5_busy", arb_if.busy, 1'b0);
    check_eq("s5_gn", arb_if.grant_n, 4'b1111);
    step(4'b1010, 1'b1);
    check_eq("s5_idx", arb_if.grant_idx, 2'd1);

    // Random requests, mostly held for a few cycles at a time.
    step(4'b0000, 1'b0);
    max_wait = 0;
    r = 4'($urandom);
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      step(r, 1'b1);
    end
    check_eq("max_wait_le_24", max_wait <= 3 * MAX_HOLD, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
